// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: pops FIFO words and streams them out in order on valid/ready.
// Latency: a word appears on data_out 2 cycles after its fifo_rd (memory read + capture).
// Backpressure: a 2-entry skid buffer absorbs the read pipeline; fifo_rd stalls when it would overfill.
module fifo_drain_ctrl #(
  parameter int BW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  input  logic [BW-1:0]    fifo_data_out,
  output logic             fifo_rd,
  output logic [BW-1:0]    data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] pop_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    occ;        // words held in head/spare
  logic          infl;       // a read issued last cycle whose data arrives now
  logic [BW-1:0] head;
  logic [BW-1:0] spare;
  logic [BW-1:0] head_nxt;
  logic [BW-1:0] spare_nxt;
  logic          pop;
  logic [2:0]    pending;    // words owned after this cycle's pop, before any new read
  logic [1:0]    occ_after_pop;

  assign valid_out     = (occ != 2'd0);
  assign data_out      = head;
  assign pop           = valid_out & ready_in;
  assign pending       = 3'(occ) + 3'(infl) - 3'(pop);
  assign occ_after_pop = occ - 2'(pop);

  // A read is only launched if its word is guaranteed a buffer slot two cycles later.
  // Held low during reset so nothing is popped from the FIFO that would then be lost.
  assign fifo_rd = reset_L & (state == DRAIN) & enable & ~fifo_empty & (pending < 3'd2);

  assign busy = (state == DRAIN) | (occ != 2'd0) | infl;

  // Next-state logic for the drain FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FILL;
      end
      FILL: begin
        if (!enable) state_nxt = IDLE;
        else if (!fifo_empty && (!fifo_almost_empty || flush)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!enable) state_nxt = IDLE;
        else if (fifo_empty && !flush) state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skid buffer: pop shifts spare into head first, then the arriving word fills the first free slot.
  always_comb begin
    head_nxt  = head;
    spare_nxt = spare;
    if (pop) head_nxt = spare;
    if (infl) begin
      if (occ_after_pop == 2'd0) head_nxt = fifo_data_out;
      else spare_nxt = fifo_data_out;
    end
  end

  // State, buffer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= IDLE;
      occ       <= 2'd0;
      infl      <= 1'b0;
      head      <= '0;
      spare     <= '0;
      pop_count <= '0;
    end else begin
      state <= state_nxt;
      occ   <= pending[1:0];
      infl  <= fifo_rd;
      head  <= head_nxt;
      spare <= spare_nxt;
      if (pop) pop_count <= pop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl: FIFO memory model plus word-level reference of the controller.
// Latency: reference expects each word on data_out 2 cycles after its read.
// Backpressure: ready_in driven by directed patterns and random stimulus.
module tb_fifo_drain_ctrl;

  localparam int BW    = 4;
  localparam int CNT_W = 3;
  localparam int AE_TH = 2;   // almost-empty when the FIFO holds this many words or fewer

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DRAIN = 2;

  logic             clk;
  logic             reset_L;
  logic             enable;
  logic             flush;
  logic             fifo_empty;
  logic             fifo_almost_empty;
  logic [BW-1:0]    fifo_data_out;
  logic             fifo_rd;
  logic [BW-1:0]    data_out;
  logic             valid_out;
  logic             ready_in;
  logic [CNT_W-1:0] pop_count;
  logic             busy;

  fifo_drain_ctrl #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_L           (reset_L),
    .enable            (enable),
    .flush             (flush),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data_out     (fifo_data_out),
    .fifo_rd           (fifo_rd),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .pop_count         (pop_count),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] v;
    int            rc;
  } word_t;

  logic [BW-1:0] fq[$];     // FIFO contents
  word_t         outq[$];   // words handed to the controller, not yet delivered
  logic [BW-1:0] dlv[$];    // words accepted downstream
  int            mstate;
  int            cyc;
  int            cnt;
  bit            dz;        // no word shown since reset, so data_out must still be zero
  int            first_rd;
  int            first_vld;
  logic          wr_en;
  logic [BW-1:0] wr_dat;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs against the reference, then advance the FIFO and the reference.
  task automatic tick();
    logic rd_e, vld_e, pop_e, busy_e;
    logic s_rst, s_rd, s_en, s_fl, s_emp, s_ae, s_wr;
    logic [BW-1:0] s_wd;
    bit   rd_word;
    int   n;
    rd_word = 0;
    fifo_empty        = (fq.size() == 0);
    fifo_almost_empty = (fq.size() <= AE_TH);
    #1;
    n      = outq.size();
    vld_e  = (n > 0) && (outq[0].rc <= cyc - 2);
    pop_e  = vld_e && ready_in;
    rd_e   = reset_L && (mstate == M_DRAIN) && enable && !fifo_empty && ((n - int'(pop_e)) < 2);
    busy_e = (mstate == M_DRAIN) || (n > 0);
    chk("fifo_rd", 32'(fifo_rd), 32'(rd_e));
    chk("valid_out", 32'(valid_out), 32'(vld_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("pop_count", 32'(pop_count), 32'(cnt % (1 << CNT_W)));
    if (vld_e) chk("data_out", 32'(data_out), 32'(outq[0].v));
    else if (dz) chk("data_out_rst", 32'(data_out), 32'd0);
    if (vld_e) dz = 0;
    if (fifo_rd === 1'b1 && first_rd < 0) first_rd = cyc;
    if (valid_out === 1'b1 && first_vld < 0) first_vld = cyc;
    if (valid_out === 1'b1 && ready_in && reset_L) dlv.push_back(data_out);
    s_rst = reset_L; s_rd = fifo_rd; s_en = enable; s_fl = flush;
    s_emp = fifo_empty; s_ae = fifo_almost_empty; s_wr = wr_en; s_wd = wr_dat;
    @(posedge clk);
    #1;
    if (s_rd === 1'b1 && fq.size() > 0) begin
      fifo_data_out = fq.pop_front();
      rd_word = 1;
    end
    if (s_wr) fq.push_back(s_wd);
    if (!s_rst) begin
      mstate = M_IDLE;
      outq.delete();
      cnt = 0;
      dz = 1;
    end else begin
      if (pop_e) begin
        void'(outq.pop_front());
        cnt++;
      end
      if (rd_word) outq.push_back('{fifo_data_out, cyc});
      case (mstate)
        M_IDLE:  if (s_en) mstate = M_FILL;
        M_FILL:  if (!s_en) mstate = M_IDLE;
                 else if (!s_emp && (!s_ae || s_fl)) mstate = M_DRAIN;
        default: if (!s_en) mstate = M_IDLE;
                 else if (s_emp && !s_fl) mstate = M_FILL;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_L = 1'b0; enable = 1'b0; flush = 1'b0; ready_in = 1'b0; wr_en = 1'b0;
    tick();
    reset_L = 1'b1;
    fq.delete();
    dlv.delete();
    first_rd = -1;
    first_vld = -1;
  endtask

  task automatic load_seq(input int n);
    for (int i = 1; i <= n; i++) fq.push_back(BW'(i));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_L = 1'b0; enable = 1'b1; flush = 1'b0; ready_in = 1'b1;
    wr_en = 1'b0; wr_dat = '0; fifo_data_out = '0;
    fifo_empty = 1'b0; fifo_almost_empty = 1'b0;
    first_rd = -1; first_vld = -1;
    load_seq(3);
    @(posedge clk);
    #1;
    @(negedge clk);
    mstate = M_IDLE; cyc = 0; cnt = 0; dz = 1;

    // Reset held for 2 clocks with a non-empty FIFO and enable high.
    for (int i = 0; i < 2; i++) tick();
    chk("rst_fifo_untouched", 32'(fq.size()), 32'd3);

    // Burst drain with ready always high.
    do_reset();
    load_seq(7);
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("burst_count", 32'(dlv.size()), 32'd7);
    for (int i = 0; i < dlv.size(); i++) chk("burst_order", 32'(dlv[i]), 32'(i + 1));
    chk("burst_latency", 32'(first_vld - first_rd), 32'd2);
    chk("burst_busy_end", 32'(busy), 32'd0);

    // Backpressure: ready low 6 clocks, high 6 clocks.
    do_reset();
    load_seq(7);
    enable = 1'b1;
    for (int i = 0; i < 48; i++) begin
      ready_in = ((i / 6) % 2) == 1;
      tick();
    end
    chk("bp_count", 32'(dlv.size()), 32'd7);
    for (int i = 0; i < dlv.size(); i++) chk("bp_order", 32'(dlv[i]), 32'(i + 1));

    // Flush below the threshold, then release flush.
    do_reset();
    fq.push_back(4'hA); fq.push_back(4'h5);
    enable = 1'b1; flush = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("flush_count", 32'(dlv.size()), 32'd2);
    chk("flush_busy_hold", 32'(busy), 32'd1);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("flush_busy_end", 32'(busy), 32'd0);

    // Disable right after the first read: that word still arrives.
    do_reset();
    load_seq(7);
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 12 && first_rd < 0; i++) tick();
    chk("dis_saw_read", 32'(first_rd >= 0), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("dis_words", 32'(dlv.size()), 32'd1);
    if (dlv.size() > 0) chk("dis_word_val", 32'(dlv[0]), 32'd1);

    // Reset right after the first read: that word is discarded.
    do_reset();
    load_seq(7);
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 12 && first_rd < 0; i++) tick();
    chk("rstmid_saw_read", 32'(first_rd >= 0), 32'd1);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1; enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rstmid_words", 32'(dlv.size()), 32'd0);

    // Counter wrap: 9 deliveries on a 3-bit counter.
    do_reset();
    load_seq(9);
    enable = 1'b1; flush = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("wrap_words", 32'(dlv.size()), 32'd9);
    chk("wrap_pop_count", 32'(pop_count), 32'd1);

    // Random traffic on all inputs, with rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_L  = ($urandom % 300) != 0;
      enable   = ($urandom % 8) != 0;
      flush    = ($urandom % 6) == 0;
      ready_in = ($urandom % 3) != 0;
      wr_en    = (fq.size() < 12) && ($urandom % 2 == 1);
      wr_dat   = BW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
